// File: rtl/stopwatch_pkg.sv
// Shared types, constants and helpers for the stopwatch core and its button front end.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } sw_state_t;

  localparam int MAX_LAPS   = 4;
  localparam int CS_PER_SEC = 100;

  function automatic int tick_div(input int clk_hz);
    return clk_hz / CS_PER_SEC;
  endfunction

  function automatic int db_cycles(input int clk_hz, input int ms);
    return (clk_hz * ms) / 1000;
  endfunction

  function automatic logic [3:0] lap_to_led(input logic [2:0] lap);
    logic [3:0] led;
    case (lap)
      3'd0:    led = 4'b0000;
      3'd1:    led = 4'b0001;
      3'd2:    led = 4'b0011;
      3'd3:    led = 4'b0111;
      default: led = 4'b1111;
    endcase
    return led;
  endfunction

  // Advance MM:SS:cc by one centisecond; any out-of-range digit is treated as its wrap point.
  function automatic logic [23:0] bcd_time_inc(input logic [23:0] t);
    logic [3:0] mt, mo, st, so, ct, co;
    {mt, mo, st, so, ct, co} = t;
    if (co < 4'd9) begin
      co = co + 4'd1;
    end else begin
      co = 4'd0;
      if (ct < 4'd9) begin
        ct = ct + 4'd1;
      end else begin
        ct = 4'd0;
        if (so < 4'd9) begin
          so = so + 4'd1;
        end else begin
          so = 4'd0;
          if (st < 4'd5) begin
            st = st + 4'd1;
          end else begin
            st = 4'd0;
            if (mo < 4'd9) begin
              mo = mo + 4'd1;
            end else begin
              mo = 4'd0;
              mt = (mt < 4'd5) ? (mt + 4'd1) : 4'd0;
            end
          end
        end
      end
    end
    return {mt, mo, st, so, ct, co};
  endfunction

endpackage

// File: rtl/stopwatch_core_debouncer.sv
// Synchronises one active-low raw button, debounces it and emits a one-cycle press pulse
// on each accepted release-to-press transition.
module button_debouncer
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 100_000,
  parameter int DEBOUNCE_TIME_MS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_in,
  output logic level_out,
  output logic press_pulse
);

  localparam int DB_RAW = db_cycles(CLK_FREQ_HZ, DEBOUNCE_TIME_MS);
  localparam int DB_CNT = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int CW     = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchroniser, stability counter and press-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
      press_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      sync1_r <= btn_n_in;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r >= CNT_LAST) begin
        level_r <= sync2_r;
        press_r <= ~sync2_r;
        cnt_r   <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign level_out   = level_r;
  assign press_pulse = press_r;

endmodule

// File: rtl/stopwatch_core.sv
// Push-button stopwatch: debounced start/stop/reset, MM:SS:cc BCD timer and lap LEDs.
// TIME_INIT only changes the post-rst time value (bring-up preload); leave it at zero otherwise.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int          CLK_FREQ_HZ      = 100_000,
  parameter int          DEBOUNCE_TIME_MS = 1,
  parameter logic [23:0] TIME_INIT        = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reset_in,
  input  logic        start_in,
  input  logic        stop_in,
  output logic [3:0]  led_out,
  output logic [23:0] bcd_data_out
);

  localparam int TICK_DIV = tick_div(CLK_FREQ_HZ);
  localparam int PW       = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [2:0]    LAP_MAX    = 3'(MAX_LAPS);

  logic reset_ev_s, start_ev_s, stop_ev_s;
  logic reset_lvl_s, start_lvl_s, stop_lvl_s;
  logic unused_lvl_s;

  sw_state_t     state_r, state_n_s;
  logic [2:0]    lap_r, lap_n_s;
  logic [PW-1:0] presc_r, presc_n_s;
  logic [23:0]   time_r, time_n_s;
  logic [3:0]    led_r;

  button_debouncer #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .DEBOUNCE_TIME_MS(DEBOUNCE_TIME_MS)) u_reset_db (
    .clk(clk), .rst(rst), .btn_n_in(reset_in), .level_out(reset_lvl_s), .press_pulse(reset_ev_s)
  );
  button_debouncer #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .DEBOUNCE_TIME_MS(DEBOUNCE_TIME_MS)) u_start_db (
    .clk(clk), .rst(rst), .btn_n_in(start_in), .level_out(start_lvl_s), .press_pulse(start_ev_s)
  );
  button_debouncer #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .DEBOUNCE_TIME_MS(DEBOUNCE_TIME_MS)) u_stop_db (
    .clk(clk), .rst(rst), .btn_n_in(stop_in), .level_out(stop_lvl_s), .press_pulse(stop_ev_s)
  );

  // Only the press pulses drive the core; the stable levels are available for future use.
  assign unused_lvl_s = &{1'b0, reset_lvl_s, start_lvl_s, stop_lvl_s};

  // Next-state logic: reset > stop > start, then prescaler/time advance while running.
  always_comb begin
    state_n_s = state_r;
    lap_n_s   = lap_r;
    presc_n_s = presc_r;
    time_n_s  = time_r;
    if (reset_ev_s) begin
      state_n_s = IDLE;
      lap_n_s   = 3'd0;
      presc_n_s = PRESC_ZERO;
      time_n_s  = 24'h000000;
    end else if (stop_ev_s && (state_r == RUN)) begin
      if (lap_r >= LAP_MAX) begin
        state_n_s = IDLE;
        lap_n_s   = 3'd0;
        presc_n_s = PRESC_ZERO;
        time_n_s  = 24'h000000;
      end else begin
        state_n_s = PAUSED;
        lap_n_s   = lap_r + 3'd1;
      end
    end else if (start_ev_s && ((state_r == IDLE) || (state_r == PAUSED))) begin
      state_n_s = RUN;
    end else if (state_r == RUN) begin
      if (presc_r >= PRESC_LAST) begin
        presc_n_s = PRESC_ZERO;
        time_n_s  = bcd_time_inc(time_r);
      end else begin
        presc_n_s = presc_r + PRESC_ONE;
      end
    end else if ((state_r == IDLE) || (state_r == PAUSED)) begin
      state_n_s = state_r;
    end else begin
      state_n_s = IDLE;
      lap_n_s   = 3'd0;
      presc_n_s = PRESC_ZERO;
      time_n_s  = 24'h000000;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      lap_r   <= 3'd0;
      presc_r <= PRESC_ZERO;
      time_r  <= TIME_INIT;
      led_r   <= 4'b0000;
    end else begin
      state_r <= state_n_s;
      lap_r   <= lap_n_s;
      presc_r <= presc_n_s;
      time_r  <= time_n_s;
      led_r   <= lap_to_led(lap_n_s);
    end
  end

  assign led_out      = led_r;
  assign bcd_data_out = time_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench: a 100 kHz instance for buttons/laps, two 100 Hz instances for carry and wrap.
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        reset_n, start_n, stop_n;
  logic        f_reset_n, f_start_n, f_stop_n;
  logic [3:0]  led, led_b, led_c;
  logic [23:0] bcd, bcd_b, bcd_c;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  logic [23:0] q_b[$];
  logic [23:0] q_c[$];
  logic        mon_en = 1'b0;
  logic [23:0] last_b = 24'h000000;
  logic [23:0] last_c = 24'h595990;

  always #5 clk = ~clk;

  stopwatch_core #(.CLK_FREQ_HZ(100_000), .DEBOUNCE_TIME_MS(1)) dut (
    .clk(clk), .rst(rst), .reset_in(reset_n), .start_in(start_n), .stop_in(stop_n),
    .led_out(led), .bcd_data_out(bcd)
  );
  stopwatch_core #(.CLK_FREQ_HZ(100), .DEBOUNCE_TIME_MS(1)) dut_b (
    .clk(clk), .rst(rst), .reset_in(f_reset_n), .start_in(f_start_n), .stop_in(f_stop_n),
    .led_out(led_b), .bcd_data_out(bcd_b)
  );
  stopwatch_core #(.CLK_FREQ_HZ(100), .DEBOUNCE_TIME_MS(1), .TIME_INIT(24'h595990)) dut_c (
    .clk(clk), .rst(rst), .reset_in(f_reset_n), .start_in(f_start_n), .stop_in(f_stop_n),
    .led_out(led_c), .bcd_data_out(bcd_c)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Centisecond count to MM:SS:cc BCD, by plain division.
  function automatic logic [23:0] enc(input int n);
    int cs, s, m;
    cs = n % 100;
    s  = (n / 100) % 60;
    m  = (n / 6000) % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic logic [3:0] therm(input int lap);
    return 4'((1 << lap) - 1);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_expect(input string tag, input int lap, input int cs_total);
    sb_item_t it;
    it.tag = tag;
    it.exp = {4'h0, therm(lap), enc(cs_total)};
    sb_q.push_back(it);
  endtask

  task automatic sb_sample();
    sb_item_t it;
    if (sb_q.size() == 0) begin
      chk_eq("sb_underflow", 32'd0, 32'd1);
    end else begin
      it = sb_q.pop_front();
      chk_eq(it.tag, {4'h0, led, bcd}, it.exp);
    end
  endtask

  // 0 = reset, 1 = start, 2 = stop; held well past the debounce window.
  task automatic press(input int which);
    if (which == 0) reset_n = 1'b0;
    else if (which == 1) start_n = 1'b0;
    else stop_n = 1'b0;
    wait_cyc(200);
    reset_n = 1'b1;
    start_n = 1'b1;
    stop_n  = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en && (bcd_b !== last_b)) begin
      if (q_b.size() != 0) chk_eq("fast_b_seq", {8'h00, bcd_b}, {8'h00, q_b.pop_front()});
      last_b <= bcd_b;
    end
  end

  always @(negedge clk) begin
    if (mon_en && (bcd_c !== last_c)) begin
      if (q_c.size() != 0) chk_eq("fast_c_wrap", {8'h00, bcd_c}, {8'h00, q_c.pop_front()});
      last_c <= bcd_c;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cum;
    int seg;
    rst = 1'b1;
    reset_n = 1'b1; start_n = 1'b1; stop_n = 1'b1;
    f_reset_n = 1'b1; f_start_n = 1'b1; f_stop_n = 1'b1;
    wait_cyc(10);
    rst = 1'b0;

    // Reset state, and no spurious event after release.
    sb_expect("reset_state", 0, 0);
    wait_cyc(100);
    sb_sample();
    sb_expect("reset_idle", 0, 0);
    wait_cyc(2000);
    sb_sample();

    // Carry chain through 01:00.00 and wrap from 59:59.99 on the fast instances.
    for (int n = 1; n <= 6001; n++) q_b.push_back(enc(n));
    for (int n = 1; n <= 20; n++) q_c.push_back(enc((359990 + n) % 360000));
    mon_en = 1'b1;
    f_start_n = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if ((q_b.size() == 0) && (q_c.size() == 0)) break;
      wait_cyc(1);
    end
    mon_en = 1'b0;
    chk_eq("fast_b_drained", 32'(q_b.size()), 32'd0);
    chk_eq("fast_c_drained", 32'(q_c.size()), 32'd0);
    chk_eq("fast_leds", {24'h0, led_b, led_c}, 32'd0);

    // Run then reset.
    press(1);
    sb_expect("run_5cs", 0, 5);
    wait_cyc(5300);
    sb_sample();
    press(0);
    sb_expect("reset_event", 0, 0);
    wait_cyc(100);
    sb_sample();
    sb_expect("reset_stays_idle", 0, 0);
    wait_cyc(2000);
    sb_sample();

    // Debounce: short glitch ignored, long hold gives exactly one start.
    start_n = 1'b0;
    wait_cyc(50);
    start_n = 1'b1;
    sb_expect("glitch_ignored", 0, 0);
    wait_cyc(2000);
    sb_sample();
    start_n = 1'b0;
    sb_expect("held_one_start", 0, 2);
    wait_cyc(2600);
    sb_sample();
    wait_cyc(1000);
    stop_n = 1'b0;
    wait_cyc(200);
    stop_n = 1'b1;
    sb_expect("held_no_repeat", 1, 3);
    wait_cyc(300);
    sb_sample();
    sb_expect("held_no_repeat_late", 1, 3);
    wait_cyc(2000);
    sb_sample();
    start_n = 1'b1;
    wait_cyc(300);
    press(0);
    sb_expect("db_cleared", 0, 0);
    wait_cyc(300);
    sb_sample();

    // Four laps: LEDs fill up, time frozen while paused and resumed on start.
    cum = 0;
    for (int lap = 1; lap <= 4; lap++) begin
      seg = (lap == 1) ? 2500 : 2000;
      press(1);
      wait_cyc(seg - 200);
      cum += seg;
      press(2);
      sb_expect($sformatf("lap%0d_paused", lap), lap, cum / 1000);
      sb_expect($sformatf("lap%0d_frozen", lap), lap, cum / 1000);
      wait_cyc(300);
      sb_sample();
      wait_cyc(400);
      sb_sample();
    end

    // Fifth stop clears everything.
    press(1);
    sb_expect("lap5_running", 4, 9);
    wait_cyc(1000);
    sb_sample();
    wait_cyc(800);
    press(2);
    sb_expect("lap5_clear", 0, 0);
    wait_cyc(100);
    sb_sample();
    sb_expect("lap5_idle", 0, 0);
    wait_cyc(2000);
    sb_sample();

    chk_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
